// File: rtl/root_seq.sv
`default_nettype none
// ============================================================================
// root_seq : sequential floor square/cube root, one result bit per clock.
// Optional: define ROOT_REM_EN to add the rem_bo remainder output.
// Revision: 1.0
// ============================================================================
module root_seq #(
  parameter int WIDTH = 8,
  localparam int RW = (WIDTH + 1) / 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] x_bi,
  output logic             busy_o,
  output logic             done_o,
  output logic [RW-1:0]    y_bo
`ifdef ROOT_REM_EN
  ,
  output logic [WIDTH-1:0] rem_bo
`endif
);

  localparam int C_N_SQ = (WIDTH + 1) / 2;
  localparam int C_N_CB = (WIDTH + 2) / 3;
  localparam int C_XW   = (2 * C_N_SQ > 3 * C_N_CB) ? 2 * C_N_SQ : 3 * C_N_CB;
  localparam int C_RMW  = WIDTH + 4;
  localparam int C_CW   = $clog2(C_N_SQ + 1);
  localparam logic [C_CW-1:0] C_LOAD_SQ = C_CW'(C_N_SQ - 1);
  localparam logic [C_CW-1:0] C_LOAD_CB = C_CW'(C_N_CB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [C_XW-1:0]   r_x;
  logic              r_mode;
  logic [RW-1:0]     r_y;
  logic [C_RMW-1:0]  r_rem;
  logic [C_CW-1:0]   r_cnt;

  logic [1:0]        w_chunk2;
  logic [2:0]        w_chunk3;
  logic [C_RMW-1:0]  w_y_ext;
  logic [C_RMW-1:0]  w_rem_sh;
  logic [C_RMW-1:0]  w_trial;
  logic [C_RMW-1:0]  w_rem_nx;
  logic              w_ge;
  logic [RW-1:0]     w_y_nx;
  logic              w_accept;
  logic              w_last;

  assign busy_o   = (r_state == S_RUN);
  assign done_o   = (r_state == S_DONE);
  assign w_accept = start_i && (r_state != S_RUN);
  assign w_last   = (r_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_state_nx = S_RUN;
      S_RUN:   if (w_last) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = start_i ? S_RUN : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // The counter indexes operand digits from the most significant end; the
  // operand is zero-extended so the top digit of either mode is in range.
  always_comb begin
    w_chunk2 = 2'(r_x >> (2 * r_cnt));
    w_chunk3 = 3'(r_x >> (3 * r_cnt));
    w_y_ext  = C_RMW'(r_y);
    if (r_mode) begin
      w_rem_sh = (r_rem << 3) | C_RMW'(w_chunk3);
      w_trial  = (C_RMW'(12) * w_y_ext * w_y_ext) + (C_RMW'(6) * w_y_ext) + C_RMW'(1);
    end else begin
      w_rem_sh = (r_rem << 2) | C_RMW'(w_chunk2);
      w_trial  = (w_y_ext << 2) + C_RMW'(1);
    end
    w_ge     = (w_rem_sh >= w_trial);
    w_rem_nx = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    w_y_nx   = {r_y[RW-2:0], w_ge};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_x    <= '0;
      r_mode <= 1'b0;
      r_y    <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      y_bo   <= '0;
`ifdef ROOT_REM_EN
      rem_bo <= '0;
`endif
    end else if (w_accept) begin
      r_x    <= C_XW'(x_bi);
      r_mode <= mode_i;
      r_y    <= '0;
      r_rem  <= '0;
      r_cnt  <= mode_i ? C_LOAD_CB : C_LOAD_SQ;
    end else if (r_state == S_RUN) begin
      r_y   <= w_y_nx;
      r_rem <= w_rem_nx;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        y_bo   <= w_y_nx;
`ifdef ROOT_REM_EN
        rem_bo <= w_rem_nx[WIDTH-1:0];
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_root_seq.sv
`default_nettype none
// ============================================================================
// tb_root_seq : randomized and directed bench for root_seq against a
// floor-root reference model (WIDTH=8), plus WIDTH=16 boundary cases.
// Revision: 1.0
// ============================================================================
module tb_root_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] x = '0;
  logic       busy;
  logic       done;
  logic [3:0] y;
  logic [7:0] rem;

  logic        start16 = 1'b0;
  logic        mode16 = 1'b0;
  logic [15:0] x16 = '0;
  logic        busy16;
  logic        done16;
  logic [7:0]  y16;
  logic [15:0] rem16;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  root_seq #(.WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start), .mode_i(mode), .x_bi(x),
    .busy_o(busy), .done_o(done), .y_bo(y)
`ifdef ROOT_REM_EN
    , .rem_bo(rem)
`endif
  );

  root_seq #(.WIDTH(16)) dut16 (
    .clk_i(clk), .rst_i(rst_n), .start_i(start16), .mode_i(mode16), .x_bi(x16),
    .busy_o(busy16), .done_o(done16), .y_bo(y16)
`ifdef ROOT_REM_EN
    , .rem_bo(rem16)
`endif
  );

`ifndef ROOT_REM_EN
  assign rem   = '0;
  assign rem16 = '0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int froot(input int xv, input bit cube);
    int r = 0;
    while ((cube ? (r + 1) * (r + 1) * (r + 1) : (r + 1) * (r + 1)) <= xv) r++;
    return r;
  endfunction

  // Reference model: transaction-level view of the unit.
  bit   m_busy = 0, m_done = 0;
  int   m_left = 0;
  int   m_y = 0, m_rem = 0, p_y = 0, p_rem = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_left = 0; m_y = 0; m_rem = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0; m_done = 1; m_y = p_y; m_rem = p_rem;
      end
    end else begin
      m_done = 0;
      if (start) begin
        m_busy = 1;
        m_left = mode ? 3 : 4;
        p_y    = froot(int'(x), mode);
        p_rem  = int'(x) - (mode ? p_y * p_y * p_y : p_y * p_y);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("y", 32'(y), 32'(m_y));
`ifdef ROOT_REM_EN
      chk("rem", 32'(rem), 32'(m_rem));
`endif
    end
  end

  // Called at a negedge with the unit idle or in its done cycle.
  task automatic run8(input logic [7:0] xv, input logic mv, output int lat);
    start = 1'b1; x = xv; mode = mv;
    @(negedge clk);
    start = 1'b0; x = 8'($urandom); mode = 1'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic lit8(input logic [7:0] xv, input logic mv, input int ey, input int er);
    int lat;
    run8(xv, mv, lat);
    chk("lit_lat", 32'(lat), mv ? 32'd3 : 32'd4);
    chk("lit_y", 32'(y), 32'(ey));
`ifdef ROOT_REM_EN
    chk("lit_rem", 32'(rem), 32'(er));
`else
    if (er < 0) chk("lit_rem_arg", 32'(er), 32'd0);
`endif
  endtask

  task automatic lit16(input logic [15:0] xv, input logic mv, input int ey, input int er);
    int lat;
    start16 = 1'b1; x16 = xv; mode16 = mv;
    @(negedge clk);
    start16 = 1'b0; x16 = 16'($urandom); mode16 = ~mv;
    lat = 0;
    while (!done16 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("w16_lat", 32'(lat), mv ? 32'd6 : 32'd8);
    chk("w16_y", 32'(y16), 32'(ey));
`ifdef ROOT_REM_EN
    chk("w16_rem", 32'(rem16), 32'(er));
`else
    if (er < 0) chk("w16_rem_arg", 32'(er), 32'd0);
`endif
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Hand-computed expectations pin the model.
    lit8(8'd87, 1'b1, 4, 23);
    lit8(8'd216, 1'b1, 6, 0);
    lit8(8'd255, 1'b1, 6, 39);
    lit8(8'd255, 1'b0, 15, 30);
    lit8(8'd0, 1'b1, 0, 0);
    lit8(8'd0, 1'b0, 0, 0);
    lit8(8'd200, 1'b0, 14, 4);
    @(negedge clk);

    lit16(16'hFFFF, 1'b1, 40, 1535);
    lit16(16'hFFFF, 1'b0, 255, 510);

    // Exhaustive sweep, back-to-back from the done cycle.
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        run8(8'(v), 1'(m), lat);
        chk("sweep_lat", 32'(lat), (m == 1) ? 32'd3 : 32'd4);
      end
    end
    @(negedge clk);

    // Start held high with the operand changing every cycle.
    start = 1'b1;
    repeat (200) begin
      x = 8'($urandom); mode = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (6) @(negedge clk);

    // Reset during the second RUN cycle.
    lit8(8'd100, 1'b0, 10, 0);
    start = 1'b1; x = 8'd200; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_y", 32'(y), 32'd0);
    repeat (6) begin
      @(negedge clk);
      chk("mid_rst_nodone", 32'(done), 32'd0);
    end
    lit8(8'd200, 1'b0, 14, 4);
    @(negedge clk);

    // Random traffic with occasional resets.
    repeat (3000) begin
      start = ($urandom_range(0, 2) == 0);
      x     = 8'($urandom);
      mode  = 1'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/root_seq.md
Name: root_seq

Overview:
- Parametrised sequential integer root unit; next generation of the fixed 8-bit cube-root block.
- Computes floor(x^(1/2)) or floor(x^(1/3)) of an unsigned WIDTH-bit operand, selected per operation by mode_i.
- Digit-by-digit (restoring) algorithm, one result bit per clock; start/busy/done handshake.
- Sits beside the other arithmetic datapath blocks; driven by a controller or bench.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.
- RW, (WIDTH+1)/2, result width; fixed by WIDTH, not to be overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-low reset.
- start_i  in  1  operation request; sampled only when busy_o=0.
- mode_i  in  1  0 = square root, 1 = cube root; latched with x_bi.
- x_bi  in  WIDTH  unsigned operand; latched on accept.
- busy_o  out  1  high while iterating.
- done_o  out  1  one-cycle pulse when y_bo holds a fresh result.
- y_bo  out  RW  root result; cube results zero-extended.
- rem_bo  out  WIDTH  remainder x - y^2 or x - y^3 (only with ROOT_REM_EN).

Behaviour:
- Reset (rst_i=0 at a clock edge): state IDLE; busy_o=0, done_o=0, y_bo=0, rem_bo=0, internal registers cleared. Reset overrides everything.
- Reset mid-operation: abandon the operation. No done_o. y_bo=0.
- Iteration count N: sqrt N=ceil(WIDTH/2); cbrt N=ceil(WIDTH/3). For WIDTH=8, sqrt N=4 and cbrt N=3.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start_i=1 (accept edge E0):
  - latch x_bi and mode_i;
  - clear working root and remainder;
  - load iteration counter with N-1;
  - busy_o=1 from E0.
- RUN: one iteration per edge E1..EN.
  - Square root: shift the next 2 operand bits into the remainder; trial = 4y+1.
  - Cube root: shift the next 3 operand bits in; trial = 3y'(y'+1)+1 with y'=2y.
  - If remainder >= trial: subtract trial, root = 2y+1; else root = 2y.
  - The operand is MSB-aligned, zero-padded on the left to a multiple of 2 or 3 bits.
- Width rules:
  - All trial and remainder arithmetic is done at WIDTH+4 bits, unsigned.
  - No truncation before comparison.
- Exit from RUN: at EN, with counter = 0, write y_bo (and rem_bo); go to DONE; busy_o=0.
- DONE (one cycle): done_o=1.
  - start_i=1 here is accepted: behaves as IDLE -> RUN.
  - Otherwise go to IDLE.
- Latency: done_o is high in the cycle after edge EN, i.e. N cycles after busy_o rises. Fixed; independent of operand value.
- y_bo and rem_bo change only on entry to DONE; they are held otherwise, including during the next RUN.
- start_i while busy_o=1: ignored; the in-flight operand is unaffected.
- x_bi/mode_i changes after accept: no effect.
- x=0: y=0, rem=0, same latency.
- x = 2^WIDTH-1: no overflow; exact floor result.

Optional Feature:
- Macro ROOT_REM_EN.
- Defined: rem_bo port exists. It carries the final remainder, with the reset and update rules of y_bo.
- Undefined: rem_bo port and its output register are absent. The internal remainder datapath remains. All other behaviour is identical.

Test Plan:
- WIDTH=8, mode=1, x=343 mod 256=87 -> y=4, rem=23; x=216 -> y=6, rem=0; done_o exactly 3 cycles after busy_o rises.
- WIDTH=8, x=255: cbrt -> y=6, rem=39; sqrt -> y=15, rem=30 (4-cycle latency); x=0 both modes -> y=0, rem=0.
- WIDTH=16, x=65535: cbrt -> y=40, rem=1535; sqrt -> y=255, rem=510. Exhaustive sweep WIDTH=8 against a floor-root model.
- start_i held high continuously, x_bi changed every cycle: each result matches the operand at its accept edge; back-to-back accept from DONE; no accept while busy_o=1.
- Assert rst_i=0 during the 2nd RUN cycle -> next edge: busy_o=0, done_o=0, y_bo=0; no done_o afterwards; a subsequent start completes normally.
- Build without ROOT_REM_EN: identical y_bo/done_o timing for all above cases.
